// File: rtl/reqc_s_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reqc_s_queue_pkg
//  Description : Shared sizing constants for the arbiter request queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package reqc_s_queue_pkg;

    localparam int REQC_DW    = 36;             // request word width
    localparam int REQC_AW    = 2;              // RAM address width
    localparam int REQC_DEPTH = 1 << REQC_AW;   // queue depth (4)

    // Pointer/count increment of the full pointer width (slot bits + wrap bit)
    localparam logic [REQC_AW:0] REQC_PTR_ONE  = (REQC_AW+1)'(1);
    localparam logic [REQC_AW:0] REQC_PTR_ZERO = '0;

endpackage : reqc_s_queue_pkg
`default_nettype wire

// File: rtl/reqc_s_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : reqc_s_queue_if
//  Description : Producer/consumer handshake bundle of the request queue.
//                slave = the queue, master = the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reqc_s_queue_if
    import reqc_s_queue_pkg::*;
#(
    parameter int DW = REQC_DW,
    parameter int AW = REQC_AW
) ();

    logic           flush;
    logic           req_valid;
    logic           req_ready;
    logic [DW-1:0]  req_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [AW:0]    count;
    logic           err_ovf;
    logic           err_unf;

    modport slave (
        input  flush, req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, count, err_ovf, err_unf
    );

    modport master (
        output flush, req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, count, err_ovf, err_unf
    );

endinterface : reqc_s_queue_if
`default_nettype wire

// File: rtl/reqc_s_1r1w.sv
`default_nettype none
// ============================================================================
//  Module      : reqc_s_1r1w
//  Description : 1-read/1-write RAM with registered read address. Read data
//                is the array word at the registered address, so a write and
//                an address update on the same edge are visible together.
//  Revision    : 1.0 - initial release
// ============================================================================
module reqc_s_1r1w
    import reqc_s_queue_pkg::*;
#(
    parameter int DW = REQC_DW,
    parameter int AW = REQC_AW
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           wen_i,
    input  wire logic [AW-1:0]  wadr_i,
    input  wire logic [DW-1:0]  wdata_i,
    input  wire logic [AW-1:0]  radr_i,
    output logic      [DW-1:0]  rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] radr_q;

    // Storage array: contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[wadr_i] <= wdata_i;
        end
    end

    // Read address register; reset only so read data is defined after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            radr_q <= '0;
        end else begin
            radr_q <= radr_i;
        end
    end

    assign rdata_o = mem_q[radr_q];

endmodule : reqc_s_1r1w
`default_nettype wire

// File: rtl/reqc_s_queue.sv
`default_nettype none
// ============================================================================
//  Module      : reqc_s_queue
//  Description : 4-entry show-ahead request queue controller. Pointers carry
//                a wrap bit to tell full from empty; the RAM read address is
//                the next-state read pointer so the oldest word is always
//                presented without a fetch cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reqc_s_queue
    import reqc_s_queue_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    reqc_s_queue_if.slave   q_if
);

    logic [REQC_AW:0] wptr_q,  wptr_d;
    logic [REQC_AW:0] rptr_q,  rptr_d;
    logic [REQC_AW:0] count_q, count_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;

    logic             full;
    logic             req_ready;
    logic             out_valid;
    logic             push;
    logic             pop;

    // Ready depends only on registered pointers: no out_ready -> req_ready path
    assign full      = (wptr_q[REQC_AW-1:0] == rptr_q[REQC_AW-1:0]) &
                       (wptr_q[REQC_AW] != rptr_q[REQC_AW]);
    assign req_ready = ~full;
    assign out_valid = (count_q != REQC_PTR_ZERO);
    assign push      = q_if.req_valid & req_ready;
    assign pop       = out_valid & q_if.out_ready;

    // Next-state pointers, occupancy and sticky error flags
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q | (q_if.req_valid & ~req_ready);
        err_unf_d = err_unf_q | (q_if.out_ready & ~out_valid);
        if (q_if.flush) begin
            // Flush wins over any push/pop issued in the same cycle
            wptr_d  = REQC_PTR_ZERO;
            rptr_d  = REQC_PTR_ZERO;
            count_d = REQC_PTR_ZERO;
        end else begin
            wptr_d = wptr_q + (push ? REQC_PTR_ONE : REQC_PTR_ZERO);
            rptr_d = rptr_q + (pop  ? REQC_PTR_ONE : REQC_PTR_ZERO);
            unique case ({push, pop})
                2'b10:   count_d = count_q + REQC_PTR_ONE;
                2'b01:   count_d = count_q - REQC_PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    reqc_s_1r1w #(
        .DW (REQC_DW),
        .AW (REQC_AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen_i   (push & ~q_if.flush),
        .wadr_i  (wptr_q[REQC_AW-1:0]),
        .wdata_i (q_if.req_data),
        .radr_i  (rptr_d[REQC_AW-1:0]),
        .rdata_o (q_if.out_data)
    );

    assign q_if.req_ready = req_ready;
    assign q_if.out_valid = out_valid;
    assign q_if.count     = count_q;
    assign q_if.err_ovf   = err_ovf_q;
    assign q_if.err_unf   = err_unf_q;

endmodule : reqc_s_queue
`default_nettype wire
